// File: rtl/fpga_cfg_pkg.sv
// Shared defaults, loader state encoding and small elaboration helpers for the
// fabric configuration loader.
package fpga_cfg_pkg;

  localparam int DEF_CFG_W    = 384;
  localparam int DEF_NUM_ROWS = 267;
  localparam int DEF_WORD_W   = 32;

  localparam int WORDS_PER_ROW = DEF_CFG_W / DEF_WORD_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_ENABLE = 3'd4,
    S_RUN    = 3'd5
  } loader_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_row_assembler.sv
// Packs WORD_W bitstream words MSB-first into one CFG_W row and flags the
// transfer that completes the row.
module cfg_row_assembler
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W  = DEF_CFG_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word,
  output logic [CFG_W-1:0]  row_data,
  output logic              row_full
);

  localparam int WPR  = CFG_W / WORD_W;
  localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;

  logic [WC_W-1:0]  word_cnt;
  logic [CFG_W-1:0] next_row;

  generate
    if (WPR > 1) begin : g_shift
      assign next_row = {row_data[CFG_W-WORD_W-1:0], word};
    end else begin : g_direct
      assign next_row = word;
    end
  endgenerate

  // Combinational: high on the transfer that delivers the last word of a row.
  assign row_full = shift_en && (word_cnt == WC_W'(WPR - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      row_data <= '0;
      word_cnt <= '0;
    end else begin
      if (clear) begin
        word_cnt <= '0;
      end else if (shift_en) begin
        word_cnt <= row_full ? '0 : word_cnt + WC_W'(1);
      end
      if (shift_en) begin
        row_data <= next_row;
      end
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams the bitstream into fabric config rows, strobes one row enable at a
// time, then releases the fabric flops (ff_en) and reports rdy.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W         = DEF_CFG_W,
  parameter int NUM_ROWS      = DEF_NUM_ROWS,
  parameter int WORD_W        = DEF_WORD_W,
  parameter int EN_PULSE      = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter int RDY_DELAY     = 10
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WORD_W-1:0]                 cfg_data,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  output logic [CFG_W-1:0]                  configs_in,
  output logic [NUM_ROWS-1:0]               configs_en,
  output logic                              ff_en,
  output logic                              rdy,
  output logic                              busy,
  output logic [$clog2(NUM_ROWS+1)-1:0]     row_idx,
  output loader_state_t                     state_dbg
);

  localparam int RI_W  = $clog2(NUM_ROWS + 1);
  localparam int CNT_W = $clog2(max3(EN_PULSE, SETTLE_CYCLES, RDY_DELAY) + 1);
  localparam logic [NUM_ROWS-1:0] EN_ONE = NUM_ROWS'(1);

  // Handshake: a word moves on every rising edge where cfg_valid and cfg_ready
  // are both high; cfg_ready is registered and only ever high in FILL.
  loader_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             transfer;
  logic             load_start;
  logic             row_full;

  assign transfer   = cfg_valid && cfg_ready;
  assign load_start = start && ((state == S_IDLE) || (state == S_RUN));
  assign state_dbg  = state;

  cfg_row_assembler #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W)
  ) u_asm (
    .clock    (clock),
    .rst      (rst),
    .clear    (load_start),
    .shift_en (transfer),
    .word     (cfg_data),
    .row_data (configs_in),
    .row_full (row_full)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cfg_ready  <= 1'b0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      busy       <= 1'b0;
      row_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FILL;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
            row_idx   <= '0;
          end
        end
        S_FILL: begin
          // The row register settles on this edge, the enable opens after it.
          if (row_full) begin
            state      <= S_WRITE;
            cfg_ready  <= 1'b0;
            configs_en <= EN_ONE << row_idx;
            cnt        <= '0;
          end
        end
        S_WRITE: begin
          if (cnt == CNT_W'(EN_PULSE - 1)) begin
            configs_en <= '0;
            row_idx    <= row_idx + RI_W'(1);
            cnt        <= '0;
            if (row_idx == RI_W'(NUM_ROWS - 1)) begin
              state <= S_SETTLE;
            end else begin
              state     <= S_FILL;
              cfg_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= S_ENABLE;
            ff_en <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ENABLE: begin
          if (cnt == CNT_W'(RDY_DELAY - 1)) begin
            state <= S_RUN;
            rdy   <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // Reconfiguration: drop the fabric back to held flops and reload.
          if (start) begin
            state     <= S_FILL;
            ff_en     <= 1'b0;
            rdy       <= 1'b0;
            row_idx   <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader with a row scoreboard and a per-cycle
// enable monitor.
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  localparam int CFG_W         = 8;
  localparam int WORD_W        = 4;
  localparam int NUM_ROWS      = 3;
  localparam int EN_PULSE      = 2;
  localparam int SETTLE_CYCLES = 3;
  localparam int RDY_DELAY     = 2;
  localparam int RI_W          = $clog2(NUM_ROWS + 1);

  logic                clock = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [WORD_W-1:0]   cfg_data = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CFG_W-1:0]    configs_in;
  logic [NUM_ROWS-1:0] configs_en;
  logic                ff_en;
  logic                rdy;
  logic                busy;
  logic [RI_W-1:0]     row_idx;
  loader_state_t       state_dbg;

  int checks = 0;
  int errors = 0;

  logic [CFG_W-1:0]    exp_q[$];
  logic [NUM_ROWS-1:0] exp_en_q[$];

  always #5 clock = ~clock;

  fpga_config_loader #(
    .CFG_W         (CFG_W),
    .NUM_ROWS      (NUM_ROWS),
    .WORD_W        (WORD_W),
    .EN_PULSE      (EN_PULSE),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .RDY_DELAY     (RDY_DELAY)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .configs_in (configs_in),
    .configs_en (configs_en),
    .ff_en      (ff_en),
    .rdy        (rdy),
    .busy       (busy),
    .row_idx    (row_idx),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    if (!cfg_ready) check("send_timeout", 32'(cfg_ready), 32'd1);
    else step();
  endtask

  task automatic expect_row(input int row, input logic [CFG_W-1:0] data);
    exp_q.push_back(data);
    exp_en_q.push_back(NUM_ROWS'(1) << row);
  endtask

  task automatic send_row(input int row, input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
    expect_row(row, {w0, w1});
    send_word(w0);
    send_word(w1);
  endtask

  task automatic send_image();
    send_row(0, 4'hA, 4'h5);
    send_row(1, 4'h3, 4'hC);
    send_row(2, 4'hF, 4'h0);
  endtask

  task automatic finish_load();
    int n;
    cfg_valid = 1'b0;
    n = 0;
    while (configs_en != '0 && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (!ff_en && n < 50) begin
      step();
      n++;
    end
    check("settle_cycles", 32'(n), 32'(SETTLE_CYCLES));
    check("rdy_before_delay", 32'(rdy), 32'd0);
    n = 0;
    while (!rdy && n < 50) begin
      step();
      n++;
    end
    check("rdy_delay", 32'(n), 32'(RDY_DELAY));
    check("run_busy", 32'(busy), 32'd0);
    check("run_ff_en", 32'(ff_en), 32'd1);
    check("run_row_idx", 32'(row_idx), 32'(NUM_ROWS));
    check("run_state", 32'(state_dbg), 32'(S_RUN));
    check("run_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rows_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Enable monitor: one-hot-or-zero every cycle, row data popped on each rising
  // enable, data and enable held for exactly EN_PULSE cycles.
  logic [NUM_ROWS-1:0] prev_en = '0;
  logic [CFG_W-1:0]    held_row = '0;
  int                  pulse_len = 0;

  always @(negedge clock) begin
    if (rst) begin
      prev_en   = '0;
      pulse_len = 0;
    end else begin
      check("en_onehot0", 32'($onehot0(configs_en)), 32'd1);
      if (configs_en != '0) begin
        if (prev_en == '0) begin
          if (exp_q.size() == 0) begin
            check("row_unexpected", 32'(configs_en), 32'd0);
          end else begin
            check("row_data", 32'(configs_in), 32'(exp_q.pop_front()));
            check("row_en", 32'(configs_en), 32'(exp_en_q.pop_front()));
          end
          held_row  = configs_in;
          pulse_len = 0;
        end else begin
          check("row_data_hold", 32'(configs_in), 32'(held_row));
          check("row_en_hold", 32'(configs_en), 32'(prev_en));
        end
        pulse_len++;
      end else if (prev_en != '0) begin
        check("en_pulse_len", 32'(pulse_len), 32'(EN_PULSE));
      end
      prev_en = configs_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    rst = 1'b0;
    check("rst_configs_in", 32'(configs_in), 32'd0);
    check("rst_configs_en", 32'(configs_en), 32'd0);
    check("rst_ff_en", 32'(ff_en), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));

    // Basic load with valid held high
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_state", 32'(state_dbg), 32'(S_FILL));
    check("start_cfg_ready", 32'(cfg_ready), 32'd1);
    send_image();
    finish_load();

    // Words offered in RUN are refused
    cfg_valid = 1'b1;
    cfg_data  = 4'h7;
    repeat (4) begin
      step();
      check("run_refuse_ready", 32'(cfg_ready), 32'd0);
      check("run_refuse_state", 32'(state_dbg), 32'(S_RUN));
    end
    cfg_valid = 1'b0;

    // Reconfiguration from RUN, with a 5-cycle stall between words 1 and 2
    pulse_start();
    check("reload_ff_en", 32'(ff_en), 32'd0);
    check("reload_rdy", 32'(rdy), 32'd0);
    check("reload_row_idx", 32'(row_idx), 32'd0);
    check("reload_state", 32'(state_dbg), 32'(S_FILL));
    expect_row(0, 8'hA5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    repeat (5) begin
      step();
      check("stall_en", 32'(configs_en), 32'd0);
      check("stall_data", 32'(configs_in), 32'h0A);
      check("stall_state", 32'(state_dbg), 32'(S_FILL));
    end
    send_word(4'h5);
    send_row(1, 4'h3, 4'hC);
    send_row(2, 4'hF, 4'h0);
    finish_load();

    // start mid-FILL is ignored, then rst during WRITE of row 1
    pulse_start();
    expect_row(0, 8'hA5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    pulse_start();
    check("midfill_row_idx", 32'(row_idx), 32'd0);
    check("midfill_state", 32'(state_dbg), 32'(S_FILL));
    send_word(4'h5);
    send_row(1, 4'h3, 4'hC);
    cfg_valid = 1'b0;
    check("pre_rst_state", 32'(state_dbg), 32'(S_WRITE));
    check("pre_rst_row_idx", 32'(row_idx), 32'd1);
    rst = 1'b1;
    step();
    check("abort_configs_in", 32'(configs_in), 32'd0);
    check("abort_configs_en", 32'(configs_en), 32'd0);
    check("abort_ff_en", 32'(ff_en), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_row_idx", 32'(row_idx), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    exp_q.delete();
    exp_en_q.delete();

    // Fresh load after the abort
    pulse_start();
    send_image();
    finish_load();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
Synthesizable configuration controller that sits directly upstream of the fpga fabric top. It accepts the bitstream as a valid/ready stream of narrow words and assembles each row into a CFG_W-wide config word. It writes the rows in order via a one-hot configs_en strobe, then asserts ff_en and rdy to release the fabric flops. It replaces file-driven behavioural loading so the fabric can be configured from an on-chip source (UART, SPI flash reader, ROM).

Parameters:
CFG_W, 384, width of fabric configs_in (bits per row); must be an integer multiple of WORD_W
NUM_ROWS, 267, number of config rows (width of configs_en)
WORD_W, 32, width of incoming bitstream word
EN_PULSE, 2, cycles the row enable is held high per row (>=1)
SETTLE_CYCLES, 10, idle cycles after last row before ff_en rises
RDY_DELAY, 10, cycles from ff_en rise to rdy rise

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a load; ignored unless in IDLE or RUN
cfg_data  in  WORD_W  bitstream word
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  loader accepts word this cycle (transfer = valid & ready)
configs_in  out  CFG_W  row data to fabric
configs_en  out  NUM_ROWS  one-hot row write enable to fabric
ff_en  out  1  fabric flop enable
rdy  out  1  fabric configured and running
busy  out  1  load in progress
row_idx  out  $clog2(NUM_ROWS+1)  rows written so far

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; configs_in=0, configs_en=0, ff_en=0, rdy=0, cfg_ready=0, busy=0, row_idx=0, word counter=0. rst overrides start and any transfer in the same cycle.
- States: IDLE, FILL, WRITE, SETTLE, ENABLE, RUN.
- IDLE: start -> FILL next cycle; busy=1 from that cycle.
- FILL: cfg_ready=1. Each transfer shifts the word into the row register; the first word of a row lands in configs_in[CFG_W-1 -: WORD_W] (MSB first, matching bitstream text order), the last in [WORD_W-1:0]. After CFG_W/WORD_W transfers -> WRITE; the final transfer's data is visible on configs_in in the WRITE cycle. cfg_valid low stalls with no state change.
- configs_in changes only in FILL, and only while configs_en==0. The fabric row latches are never open while data moves.
- WRITE: cfg_ready=0; configs_en[row_idx]=1, all other bits 0, for exactly EN_PULSE cycles; configs_in held. On exit configs_en=0 and row_idx increments. If row_idx == NUM_ROWS, go to SETTLE; otherwise return to FILL.
- SETTLE: counts SETTLE_CYCLES, then -> ENABLE with ff_en=1.
- ENABLE: ff_en=1; after RDY_DELAY cycles rdy=1 -> RUN; busy=0 in RUN.
- RUN: ff_en=1, rdy=1, cfg_ready=0; words are ignored. start in RUN: ff_en=0, rdy=0 and row_idx=0 on the next cycle -> FILL (reconfiguration).
- Extra words beyond NUM_ROWS*CFG_W/WORD_W are never accepted (cfg_ready=0 outside FILL).
- start during FILL/WRITE/SETTLE/ENABLE is ignored. Only rst aborts a load; mid-load rst leaves the fabric partially written with ff_en=0.
- configs_en is never multi-hot; at most one bit is high in any cycle.

Decomposition:
- Shared package fpga_cfg_pkg: CFG_W, NUM_ROWS and WORD_W defaults; state enum loader_state_t; localparam WORDS_PER_ROW = CFG_W/WORD_W.
- One natural sub-module: cfg_row_assembler (WORD_W-to-CFG_W shift register plus word counter, with a row_full flag). The FSM, counters and one-hot enable generator stay in the top.

Test Plan:
- Bench parameters CFG_W=8, WORD_W=4, NUM_ROWS=3, EN_PULSE=2, SETTLE_CYCLES=3, RDY_DELAY=2; rst then start.
- Feed words 0xA,0x5,0x3,0xC,0xF,0x0 with valid always high -> configs_in=0xA5 with configs_en=3'b001 for 2 cycles, then 0x3C with 3'b010, then 0xF0 with 3'b100. ff_en rises 3 cycles after the last enable falls; rdy rises 2 cycles later; busy=0.
- Same stream with cfg_valid low for 5 cycles between words 1 and 2 -> identical row data. configs_en stays 0 during the stall and configs_in is unchanged.
- Assert rst while row 1 is in WRITE -> next cycle all outputs are 0 and the state is IDLE. A fresh start plus 6 words completes normally with row_idx=3.
- In RUN, drive cfg_valid=1 with data 0x7 -> cfg_ready stays 0. Pulse start -> ff_en=0, rdy=0 the next cycle, and a full reload completes.
- Pulse start mid-FILL -> ignored; no row_idx or word-count change. The assertion that configs_en is one-hot-or-zero holds every cycle of all tests.
